mem_line_server: RTL and testbench

- Memory-side responder for the CPU's split instruction/data cache line interface. It answers line-fill reads and line write-backs from the I-cache and D-cache.
- Holds a line-organised backing store: one line is 64 bits, i.e. 4 x 16-bit words.
- Arbitrates between the two request ports and serves one transaction at a time.
- Fixed programmable latency, with a one-cycle ready pulse per transaction. Replaces the zero-latency bench memory in cache-timing experiments.

---
 rtl/mem_if_pkg.sv | 27 ++
 rtl/mem_line_array.sv | 31 +++
 rtl/mem_line_server.sv | 119 +++++++++++
 tb/tb_mem_line_server.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// Shared definitions for the cache-line memory interface: line geometry,
// FSM/owner encodings, the accepted-request record and the line-index helper.
package mem_if_pkg;

  localparam int WORD_SIZE      = 16;
  localparam int LINE_SIZE      = 64;
  localparam int WORDS_PER_LINE = 4;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic       {OWN_I, OWN_D}     owner_t;

  // One accepted transaction; the full word address is kept and reduced to
  // a line index where the array is addressed.
  typedef struct packed {
    owner_t                 owner;
    logic                   wr;
    logic [WORD_SIZE-1:0]   addr;
    logic [LINE_SIZE-1:0]   wdata;
  } line_req_t;

  // Word address -> line index: drop the word-in-line bits. Callers truncate
  // to their index width, so upper bits alias.
  function automatic logic [WORD_SIZE-3:0] line_idx(input logic [WORD_SIZE-1:0] addr);
    return addr[WORD_SIZE-1:2];
  endfunction

endpackage

// File: rtl/mem_line_array.sv
// LINES x 64-bit single-port line store with a registered read-out.
// The storage itself is never reset; only the read register is.
module mem_line_array
  import mem_if_pkg::*;
#(
  parameter int LINES = 16384,
  parameter int IDX_W = $clog2(LINES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic                 re,
  input  logic [IDX_W-1:0]     idx,
  input  logic [LINE_SIZE-1:0] wdata,
  output logic [LINE_SIZE-1:0] rdata
);

  logic [LINE_SIZE-1:0] mem [LINES];

  // Line write.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  // Registered read-out, valid the cycle after re.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/mem_line_server.sv
// Fixed-latency line server for the split I/D cache interface. One
// transaction at a time, D-side has fixed priority, one-cycle ready pulse.
module mem_line_server
  import mem_if_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int LINES   = 16384
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_readM,
  input  logic [15:0]          i_address,
  output logic [63:0]          i_rdata,
  output logic                 i_ready,
  input  logic                 d_readM,
  input  logic                 d_writeM,
  input  logic [15:0]          d_address,
  input  logic [63:0]          d_wdata,
  output logic [63:0]          d_rdata,
  output logic                 d_ready,
  output logic                 protocol_err,
  output logic [15:0]          i_req_count,
  output logic [15:0]          d_req_count
);

  localparam int         IDX_W    = $clog2(LINES);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t               state, state_nx;
  logic [3:0]           cnt;
  line_req_t            req_q, req_new, cur;
  logic                 d_any, accept, enter_resp;
  logic                 arr_we, arr_re;
  logic [IDX_W-1:0]     arr_idx;
  logic [LINE_SIZE-1:0] arr_q, i_rdata_q, d_rdata_q;

  assign d_any  = d_readM | d_writeM;
  assign accept = (state == IDLE) & (d_any | i_readM);

  // Request that would be accepted this cycle (D wins; read+write is a write).
  always_comb begin
    req_new       = '0;
    req_new.owner = d_any ? OWN_D : OWN_I;
    req_new.wr    = d_any & d_writeM;
    req_new.addr  = d_any ? d_address : i_address;
    req_new.wdata = d_wdata;
  end

  // With LATENCY=1 the array is touched on the acceptance edge itself, so
  // use the live request there and the latched one otherwise.
  assign cur        = (state == IDLE) ? req_new : req_q;
  assign enter_resp = ((state == IDLE) & accept & (LATENCY == 1)) |
                      ((state == BUSY) & (cnt == 4'd1));
  assign arr_we     = enter_resp & cur.wr;
  assign arr_re     = enter_resp & ~cur.wr;
  assign arr_idx    = IDX_W'(line_idx(cur.addr));

  mem_line_array #(.LINES(LINES), .IDX_W(IDX_W)) u_arr (
    .clk   (clk),
    .reset (reset),
    .we    (arr_we),
    .re    (arr_re),
    .idx   (arr_idx),
    .wdata (cur.wdata),
    .rdata (arr_q)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state: IDLE -> BUSY/RESP on accept, BUSY counts down, RESP lasts one cycle.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = (LATENCY == 1) ? RESP : BUSY;
      BUSY: if (cnt == 4'd1) state_nx = RESP;
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request latch, latency counter, counters, sticky error and held read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q        <= '0;
      cnt          <= '0;
      i_req_count  <= '0;
      d_req_count  <= '0;
      protocol_err <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      if (accept) begin
        req_q <= req_new;
        cnt   <= CNT_INIT;
        if (d_any) d_req_count <= d_req_count + 16'd1;
        else       i_req_count <= i_req_count + 16'd1;
        if (d_readM & d_writeM) protocol_err <= 1'b1;
      end else if (state == BUSY) begin
        cnt <= cnt - 4'd1;
      end
      if ((state == RESP) & ~req_q.wr) begin
        if (req_q.owner == OWN_I) i_rdata_q <= arr_q;
        else                      d_rdata_q <= arr_q;
      end
    end
  end

  // Ready pulses; the read line comes straight from the array register in
  // the ready cycle and from the owner's hold register afterwards.
  assign i_ready = (state == RESP) & (req_q.owner == OWN_I);
  assign d_ready = (state == RESP) & (req_q.owner == OWN_D);
  assign i_rdata = (i_ready & ~req_q.wr) ? arr_q : i_rdata_q;
  assign d_rdata = (d_ready & ~req_q.wr) ? arr_q : d_rdata_q;

endmodule

// File: tb/tb_mem_line_server.sv
// Directed bench for mem_line_server: a LATENCY=4 instance for the main
// scenarios and a LATENCY=1, 64-line instance for back-to-back and aliasing.
module tb_mem_line_server;

  localparam logic [63:0] P10 = 64'h0004_0003_0002_0001;
  localparam logic [63:0] P5  = 64'h5555_6666_7777_8888;
  localparam logic [63:0] WA  = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [63:0] W7  = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] WX  = 64'hDEAD_BEEF_DEAD_BEEF;
  localparam logic [63:0] L1  = 64'h1111_2222_3333_4444;
  localparam logic [63:0] L2  = 64'h9999_8888_7777_6666;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // LATENCY=4 instance
  logic        i_readM = 0, d_readM = 0, d_writeM = 0;
  logic [15:0] i_address = 0, d_address = 0;
  logic [63:0] d_wdata = 0, i_rdata, d_rdata;
  logic        i_ready, d_ready, protocol_err;
  logic [15:0] i_req_count, d_req_count;

  // LATENCY=1 instance
  logic        i_readM1 = 0, d_readM1 = 0, d_writeM1 = 0;
  logic [15:0] i_address1 = 0, d_address1 = 0;
  logic [63:0] d_wdata1 = 0, i_rdata1, d_rdata1;
  logic        i_ready1, d_ready1, protocol_err1;
  logic [15:0] i_req_count1, d_req_count1;

  mem_line_server #(.LATENCY(4)) dut (
    .clk(clk), .reset(reset),
    .i_readM(i_readM), .i_address(i_address), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_readM(d_readM), .d_writeM(d_writeM), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready), .protocol_err(protocol_err),
    .i_req_count(i_req_count), .d_req_count(d_req_count)
  );

  mem_line_server #(.LATENCY(1), .LINES(64)) dut1 (
    .clk(clk), .reset(reset),
    .i_readM(i_readM1), .i_address(i_address1), .i_rdata(i_rdata1), .i_ready(i_ready1),
    .d_readM(d_readM1), .d_writeM(d_writeM1), .d_address(d_address1), .d_wdata(d_wdata1),
    .d_rdata(d_rdata1), .d_ready(d_ready1), .protocol_err(protocol_err1),
    .i_req_count(i_req_count1), .d_req_count(d_req_count1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
  endtask

  // D-side transaction on dut; lat = edges from acceptance (edge 1) to ready.
  task automatic d_xact(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [63:0] wd, output int lat, output logic [63:0] rdat,
                        output int iseen);
    d_readM = rd; d_writeM = wr; d_address = a; d_wdata = wd;
    lat = 0; iseen = 0; rdat = '0;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (i_ready) iseen++;
      if (d_ready) begin lat = n; rdat = d_rdata; break; end
    end
    d_readM = 0; d_writeM = 0;
    step();
    chk("d_single_pulse", {63'd0, d_ready}, 64'd0);
  endtask

  // I-side read on dut.
  task automatic i_xact(input logic [15:0] a, output int lat, output logic [63:0] rdat,
                        output int dseen);
    i_readM = 1; i_address = a;
    lat = 0; dseen = 0; rdat = '0;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (d_ready) dseen++;
      if (i_ready) begin lat = n; rdat = i_rdata; break; end
    end
    i_readM = 0;
    step();
    chk("i_single_pulse", {63'd0, i_ready}, 64'd0);
  endtask

  task automatic d1_write(input logic [15:0] a, input logic [63:0] wd);
    d_writeM1 = 1; d_address1 = a; d_wdata1 = wd;
    for (int n = 1; n <= 10; n++) begin
      step();
      if (d_ready1) break;
    end
    d_writeM1 = 0;
    step();
  endtask

  task automatic i1_read(input logic [15:0] a, output int lat, output logic [63:0] rdat);
    i_readM1 = 1; i_address1 = a; lat = 0; rdat = '0;
    for (int n = 1; n <= 10; n++) begin
      step();
      if (i_ready1) begin lat = n; rdat = i_rdata1; break; end
    end
    i_readM1 = 0;
    step();
  endtask

  initial begin
    int lat, lat2, seen, dn, in_;
    logic [63:0] rd, drd, ird;

    do_reset();
    // reset state
    chk("rst_i_ready", {63'd0, i_ready}, 64'd0);
    chk("rst_d_ready", {63'd0, d_ready}, 64'd0);
    chk("rst_perr",    {63'd0, protocol_err}, 64'd0);
    chk("rst_i_rdata", i_rdata, 64'd0);
    chk("rst_d_rdata", d_rdata, 64'd0);
    chk("rst_i_cnt",   {48'd0, i_req_count}, 64'd0);
    chk("rst_d_cnt",   {48'd0, d_req_count}, 64'd0);

    // preload through the D port, then reset (array survives, counters clear)
    d_xact(1'b0, 1'b1, 16'h0040, P10, lat, rd, seen);
    d_xact(1'b0, 1'b1, 16'h0014, P5,  lat, rd, seen);
    do_reset();
    chk("post_rst_d_cnt", {48'd0, d_req_count}, 64'd0);

    // basic I read of line 0x10
    i_xact(16'h0040, lat, rd, seen);
    chk("iread_lat",   64'(lat), 64'd4);
    chk("iread_data",  rd, P10);
    chk("iread_no_d",  64'(seen), 64'd0);
    chk("iread_count", {48'd0, i_req_count}, 64'd1);

    // D write to line 0x10, then I read of another word in the same line
    d_xact(1'b0, 1'b1, 16'h0041, WA, lat, rd, seen);
    chk("dwrite_lat", 64'(lat), 64'd4);
    i_xact(16'h0043, lat, rd, seen);
    chk("raw_data",   rd, WA);
    chk("raw_i_cnt",  {48'd0, i_req_count}, 64'd2);
    chk("raw_d_cnt",  {48'd0, d_req_count}, 64'd1);

    // simultaneous I and D requests: D first, I 1+LATENCY cycles later
    do_reset();
    d_readM = 1; d_address = 16'h0040; i_readM = 1; i_address = 16'h0014;
    dn = 0; in_ = 0; drd = '0; ird = '0;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (d_ready) begin dn = n; drd = d_rdata; d_readM = 0; end
      if (i_ready) begin in_ = n; ird = i_rdata; i_readM = 0; break; end
    end
    step();
    chk("arb_d_lat",  64'(dn), 64'd4);
    chk("arb_i_gap",  64'(in_ - dn), 64'd5);
    chk("arb_d_data", drd, WA);
    chk("arb_i_data", ird, P5);
    chk("arb_i_cnt",  {48'd0, i_req_count}, 64'd1);
    chk("arb_d_cnt",  {48'd0, d_req_count}, 64'd1);

    // read+write together: behaves as a write, sticky error
    d_xact(1'b1, 1'b1, 16'h001C, W7, lat, rd, seen);
    chk("perr_set", {63'd0, protocol_err}, 64'd1);
    d_xact(1'b1, 1'b0, 16'h001C, 64'd0, lat, rd, seen);
    chk("perr_wrote", rd, W7);
    chk("perr_sticky", {63'd0, protocol_err}, 64'd1);
    chk("nonowner_i_rdata", i_rdata, P5);
    chk("d_rdata_held", d_rdata, W7);

    // reset two cycles into a write of line 5: write is dropped
    d_writeM = 1; d_address = 16'h0014; d_wdata = WX;
    step(); step();
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_d_ready", {63'd0, d_ready}, 64'd0);
    chk("mid_rst_d_rdata", d_rdata, 64'd0);
    d_writeM = 0;
    step();
    reset = 1'b0;
    seen = 0;
    for (int n = 0; n < 8; n++) begin
      step();
      if (d_ready) seen++;
    end
    chk("mid_rst_no_ready", 64'(seen), 64'd0);
    chk("mid_rst_perr", {63'd0, protocol_err}, 64'd0);
    i_xact(16'h0014, lat, rd, seen);
    chk("mid_rst_old_data", rd, P5);

    // LATENCY=1 instance: back-to-back reads and index aliasing
    d1_write(16'h0004, L1);
    d1_write(16'h0008, L2);
    do_reset();
    i1_read(16'h0004, lat, rd);
    i1_read(16'h0009, lat2, ird);
    chk("l1_lat_a",  64'(lat), 64'd1);
    chk("l1_data_a", rd, L1);
    chk("l1_lat_b",  64'(lat2), 64'd1);
    chk("l1_data_b", ird, L2);
    chk("l1_i_cnt",  {48'd0, i_req_count1}, 64'd2);
    i1_read(16'h0104, lat, rd);
    chk("l1_alias", rd, L1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case a wait loop is ever bypassed.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
